// File: rtl/chanx_pkg.sv
// Shared constants and helpers for the channel-X receive buffer.
package chanx_pkg;

   localparam int CHAN_WIDTH    = 32;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DROP_CNT_W    = 8;

   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

   // Saturating increment for the dropped-word counter.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      logic [DROP_CNT_W-1:0] r;
      if (v == DROP_CNT_MAX) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/chanx_rx_fifo_if.sv
// Channel-X receive buffer bus: incoming words, outgoing head word and status.
interface chanx_rx_fifo_if
   import chanx_pkg::*;
#(
   parameter int WIDTH = CHAN_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
);

   logic [WIDTH-1:0]           chanx_left_in;
   logic                       chanx_left_in_valid;
   logic [WIDTH-1:0]           chanx_right_out;
   logic                       chanx_right_out_valid;
   logic                       chanx_right_out_ready;
   logic [$clog2(DEPTH):0]     occupancy;
   logic                       overflow;
   logic [DROP_CNT_W-1:0]      drop_count;

   // Driver side: the switch block sending words and the consumer accepting them.
   modport master (
      output chanx_left_in, chanx_left_in_valid, chanx_right_out_ready,
      input  chanx_right_out, chanx_right_out_valid, occupancy, overflow, drop_count
   );

   // Buffer side.
   modport slave (
      input  chanx_left_in, chanx_left_in_valid, chanx_right_out_ready,
      output chanx_right_out, chanx_right_out_valid, occupancy, overflow, drop_count
   );

endinterface

// File: rtl/chanx_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// A read of the address being written in the same cycle returns the new word,
// which is what lets a word pushed into an empty buffer appear one cycle later.
module chanx_fifo_mem
   import chanx_pkg::*;
#(
   parameter int WIDTH = CHAN_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // Storage array write; contents need no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port with write-through on an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r <= {WIDTH{1'b0}};
      end else if (re) begin
         if (we && (waddr == raddr)) begin
            rdata_r <= wdata;
         end else begin
            rdata_r <= mem_r[raddr];
         end
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/chanx_rx_fifo.sv
// Receive buffer for a routing-channel word stream with no sender backpressure.
// The head word comes straight from the memory read register; the read address
// already accounts for this cycle's pop so the next head is ready one edge later.
module chanx_rx_fifo
   import chanx_pkg::*;
#(
   parameter int WIDTH = CHAN_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic            clk,
   input logic            reset,
   chanx_rx_fifo_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, rd_addr_s;
   logic [OCC_W-1:0]      occ_r, occ_next_s;
   logic                  valid_r, overflow_r;
   logic [DROP_CNT_W-1:0] drop_cnt_r;
   logic                  push_s, pop_s, drop_s, we_s, re_s;
   logic [WIDTH-1:0]      rdata_s;

   // Push/pop decision, next occupancy and read address for the next head.
   always_comb begin
      pop_s      = valid_r & bus.chanx_right_out_ready;
      push_s     = bus.chanx_left_in_valid & ((occ_r != OCC_FULL) | pop_s);
      drop_s     = bus.chanx_left_in_valid & ~push_s;
      occ_next_s = occ_r;
      case ({push_s, pop_s})
         2'b10:   occ_next_s = occ_r + OCC_W'(1);
         2'b01:   occ_next_s = occ_r - OCC_W'(1);
         default: occ_next_s = occ_r;
      endcase
      if (pop_s) begin
         rd_addr_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_addr_s = rd_ptr_r;
      end
      we_s = push_s & ~reset;
      re_s = (occ_next_s != {OCC_W{1'b0}}) & ~reset;
   end

   // Pointers, occupancy, valid and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         occ_r      <= {OCC_W{1'b0}};
         valid_r    <= 1'b0;
         overflow_r <= 1'b0;
         drop_cnt_r <= {DROP_CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         rd_ptr_r <= rd_addr_s;
         occ_r    <= occ_next_s;
         valid_r  <= (occ_next_s != {OCC_W{1'b0}});
         if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= sat_inc(drop_cnt_r);
         end
      end
   end

   chanx_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (we_s),
      .waddr (wr_ptr_r),
      .wdata (bus.chanx_left_in),
      .re    (re_s),
      .raddr (rd_addr_s),
      .rdata (rdata_s)
   );

   assign bus.chanx_right_out       = rdata_s;
   assign bus.chanx_right_out_valid = valid_r;
   assign bus.occupancy             = occ_r;
   assign bus.overflow              = overflow_r;
   assign bus.drop_count            = drop_cnt_r;

endmodule

// File: tb/tb_chanx_rx_fifo.sv
// Self-checking bench for chanx_rx_fifo against a queue-based reference model.
module tb_chanx_rx_fifo;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   logic [31:0] q[$];
   bit          ov_m;
   int          dc_m;
   bit          fresh_m;

   chanx_rx_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

   chanx_rx_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("valid", 32'(bus.chanx_right_out_valid), 32'(q.size() != 0));
      chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
      chk("overflow", 32'(bus.overflow), 32'(ov_m));
      chk("drop_count", 32'(bus.drop_count), 32'(dc_m));
      if (q.size() != 0) chk("head_data", bus.chanx_right_out, q[0]);
      else if (fresh_m)  chk("data_after_reset", bus.chanx_right_out, 32'd0);
   endtask

   // One clock: model the edge from the specification's rules, then check.
   task automatic tick();
      bit push, pop;
      @(posedge clk);
      if (reset) begin
         q.delete();
         ov_m    = 1'b0;
         dc_m    = 0;
         fresh_m = 1'b1;
      end else begin
         pop  = (q.size() != 0) && bus.chanx_right_out_ready;
         push = bus.chanx_left_in_valid && ((q.size() < DEPTH) || pop);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(bus.chanx_left_in);
            fresh_m = 1'b0;
         end else if (bus.chanx_left_in_valid) begin
            ov_m = 1'b1;
            if (dc_m < 255) dc_m++;
         end
      end
      #1;
      check_all();
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input bit r);
      bus.chanx_left_in_valid   = v;
      bus.chanx_left_in         = d;
      bus.chanx_right_out_ready = r;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] prev;
      n_pass  = 0;
      n_total = 0;
      ov_m    = 1'b0;
      dc_m    = 0;
      fresh_m = 1'b1;
      reset   = 1'b1;
      drive(1'b0, 32'd0, 1'b0);

      // Reset state.
      do_reset();
      drive(1'b0, 32'd0, 1'b0);
      tick();

      // Single push into an empty buffer with the consumer stalled.
      drive(1'b1, 32'hA5A5_0001, 1'b0);
      tick();
      chk("first_word", bus.chanx_right_out, 32'hA5A5_0001);
      chk("first_occ", 32'(bus.occupancy), 32'd1);

      // Fill to four, then a fifth with no pop is dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom(), 1'b0);
         tick();
      end
      drive(1'b1, 32'hDEAD_BEEF, 1'b0);
      tick();
      chk("full_occ", 32'(bus.occupancy), 32'd4);
      chk("full_overflow", 32'(bus.overflow), 32'd1);
      chk("full_drop", 32'(bus.drop_count), 32'd1);
      // Drain in order; stall on one cycle to confirm the head holds still.
      drive(1'b0, 32'd0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'd0, 1'b1);
         tick();
      end
      drive(1'b0, 32'd0, 1'b0);

      // Full buffer with a simultaneous push and pop: no drop, new word last.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, $urandom(), 1'b0);
         tick();
      end
      drive(1'b1, 32'h0000_00FF, 1'b1);
      tick();
      chk("pp_full_occ", 32'(bus.occupancy), 32'd4);
      chk("pp_full_drop", 32'(bus.drop_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'd0, 1'b1);
         tick();
      end
      chk("pp_last_word", bus.chanx_right_out, 32'h0000_00FF);
      drive(1'b0, 32'd0, 1'b1);
      tick();

      // Streaming: outputs are inputs delayed by one cycle, occupancy at most 1.
      do_reset();
      prev = 32'd0;
      for (int i = 0; i < 20; i++) begin
         logic [31:0] d;
         d = $urandom();
         drive(1'b1, d, 1'b1);
         tick();
         chk("stream_occ_le1", 32'(bus.occupancy <= 3'd1), 32'd1);
         chk("stream_delay", bus.chanx_right_out, d);
         if (i > 0) chk("stream_prev_gone", 32'(bus.chanx_right_out != prev), 32'd1);
         prev = d;
      end
      drive(1'b0, 32'd0, 1'b1);
      tick();

      // Saturation of the drop counter.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, $urandom(), 1'b0);
         tick();
      end
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, $urandom(), 1'b0);
         tick();
      end
      chk("sat_drop", 32'(bus.drop_count), 32'd255);
      chk("sat_overflow", 32'(bus.overflow), 32'd1);

      // Reset mid-stream with occupancy 3 and a push/pop presented.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom(), 1'b0);
         tick();
      end
      chk("pre_reset_occ", 32'(bus.occupancy), 32'd3);
      reset = 1'b1;
      drive(1'b1, $urandom(), 1'b1);
      tick();
      reset = 1'b0;
      drive(1'b0, 32'd0, 1'b0);
      chk("rst_valid", 32'(bus.chanx_right_out_valid), 32'd0);
      chk("rst_occ", 32'(bus.occupancy), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_drop", 32'(bus.drop_count), 32'd0);
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 99) < 60), $urandom(), 1'($urandom_range(0, 99) < 45));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
